// File: rtl/prog_tick_timer.sv
// Programmable tick timer: counts tick_in strobes and raises a one-cycle timeout
// every period ticks, in periodic or one-shot mode.
module prog_tick_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_in,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic [WIDTH-1:0] period,
    output logic             timeout,
    output logic             busy,
    output logic [WIDTH-1:0] count,
    output logic [7:0]       n_timeouts
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] period_q;
    logic             mode_q;
    logic             load;
    logic             at_end;
    logic             wrap;

    // stop outranks start in both states, so a start with stop is never accepted
    assign load   = start && (period != '0) && !stop;
    assign at_end = (count == period_q - {{(WIDTH-1){1'b0}}, 1'b1});
    assign wrap   = (state == RUN) && !stop && !load && tick_in && at_end;

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (load) state_next = RUN;
            RUN: begin
                if (stop)               state_next = IDLE;
                else if (load)          state_next = RUN;
                else if (wrap && mode_q) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            period_q   <= '0;
            mode_q     <= 1'b0;
            count      <= '0;
            n_timeouts <= '0;
            timeout    <= 1'b0;
        end else begin
            timeout <= 1'b0;
            if (state == IDLE) begin
                if (load) begin
                    period_q   <= period;
                    mode_q     <= mode;
                    count      <= '0;
                    n_timeouts <= '0;
                end
            end else if (stop) begin
                count <= '0;
            end else if (load) begin
                // restart discards any tick arriving in the same cycle
                period_q   <= period;
                mode_q     <= mode;
                count      <= '0;
                n_timeouts <= '0;
            end else if (tick_in) begin
                if (at_end) begin
                    timeout <= 1'b1;
                    count   <= '0;
                    if (n_timeouts != 8'hFF) n_timeouts <= n_timeouts + 8'd1;
                end else begin
                    count <= count + {{(WIDTH-1){1'b0}}, 1'b1};
                end
            end
        end
    end

endmodule

// File: doc/prog_tick_timer.md
PROG_TICK_TIMER -- requirements
Module: prog_tick_timer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning the bit width of the period and of the tick counter.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port tick_in, input, 1 bit: one-cycle strobe (e.g. 1 ms timebase); each high cycle is one tick.
REQ-005 The block SHALL have port start, input, 1 bit: a one-cycle request to load the period and begin counting.
REQ-006 The block SHALL have port stop, input, 1 bit: a one-cycle request to abort counting.
REQ-007 The block SHALL have port mode, input, 1 bit: 0 = periodic, 1 = one-shot; sampled only with start.
REQ-008 The block SHALL have port period, input, WIDTH bits: ticks per timeout; sampled only with start.
REQ-009 The block SHALL have port timeout, output, 1 bit: registered one-cycle pulse at the end of each period.
REQ-010 The block SHALL have port busy, output, 1 bit: high while in state RUN.
REQ-011 The block SHALL have port count, output, WIDTH bits: ticks counted in the current period.
REQ-012 The block SHALL have port n_timeouts, output, 8 bits: number of timeouts since the last accepted start, saturating at 255.

Function
REQ-013 The block SHALL implement two states, IDLE and RUN; busy SHALL be 1 exactly when the state is RUN.
REQ-014 In IDLE, start=1 with period!=0 and stop=0 SHALL latch period_q<=period and mode_q<=mode, set count<=0 and n_timeouts<=0, and enter RUN.
REQ-015 In IDLE, start=1 with period==0 SHALL be ignored: the block stays in IDLE and no output changes.
REQ-016 In IDLE, tick_in and stop SHALL be ignored.
REQ-017 In RUN, tick_in=1 with count!=period_q-1 SHALL increment count by 1.
REQ-018 In RUN, tick_in=1 with count==period_q-1 SHALL, on that edge, set timeout<=1 and count<=0 and increment n_timeouts (saturating); the timeout is therefore on exactly the period_q-th tick.
REQ-019 On the edge of REQ-018, periodic mode SHALL stay in RUN and one-shot mode SHALL go to IDLE, so busy falls on the same edge that timeout rises.
REQ-020 timeout SHALL be 0 on every edge not described in REQ-018; it is never wider than one cycle, even when tick_in is high continuously.
REQ-021 In RUN, stop=1 SHALL go to IDLE with count<=0 and SHALL suppress any timeout from a tick in the same cycle.
REQ-022 In RUN, start=1 with stop=0 and period!=0 SHALL restart as in REQ-014; a tick in the same cycle SHALL be discarded and no timeout SHALL be produced.
REQ-023 In RUN, start=1 with period==0 SHALL be ignored, and the run continues.
REQ-024 Priority in any cycle SHALL be: rst, then stop, then start, then tick_in.
REQ-025 Changes on period or mode while in RUN SHALL have no effect until the next accepted start.
REQ-026 When period_q is all-ones, count SHALL reach 2^WIDTH-2 and then wrap to 0 with a timeout; count SHALL never overflow.

Reset
REQ-027 On a clk edge with rst=0, the block SHALL go to IDLE with count=0, timeout=0, busy=0, n_timeouts=0, period_q=0 and mode_q=0, overriding all other inputs.
REQ-028 rst=0 in the middle of a run SHALL abort the run with no timeout, including when tick_in is high on the reset edge.

Verification
REQ-029 The bench SHALL cover periodic mode: period=100, mode=0, start, then 250 ticks spaced 3 cycles apart -> timeout pulses after ticks 100 and 200, count=50 at the end, busy=1 throughout, n_timeouts=2.
REQ-030 The bench SHALL cover one-shot mode: period=5, mode=1, start, then tick_in held high -> a single timeout on the edge of the 5th tick, busy=0 on that same edge, count=0, and no further timeouts.
REQ-031 The bench SHALL cover stop priority: period=4, three ticks, then stop and tick_in in the same cycle -> IDLE, count=0, no timeout, n_timeouts=0.
REQ-032 The bench SHALL cover restart: period=10, seven ticks, then start with period=3 and a tick in the same cycle -> count=0, and the next timeout comes after 3 further ticks.
REQ-033 The bench SHALL cover zero period and reset: start with period=0 -> busy stays 0; start with period=2, one tick, then rst=0 together with a tick -> all outputs 0 and no timeout.
REQ-034 The bench SHALL cover saturation and width: WIDTH=4, period=15, periodic mode, 300 periods -> n_timeouts holds at 255, and count wraps from 14 to 0 each period.
